// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: bytes in at up to one per clock, popped one per frame.
// Latency: write -> o_tx_data_avail two edges later when idle; a full FIFO drops writes and pulses o_overflow.

module fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DAT_W-1:0]  i_wr_data,
    input  logic              i_rd_en,
    output logic [DAT_W-1:0]  o_rd_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [DAT_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Fullness and emptiness are judged from the count at the start of the cycle.
    assign o_full    = (r_count == LP_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_wr_ok   = i_wr_en && !o_full;
    assign w_rd_ok   = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [7:0]        i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_tx_data_avail,
    output logic [7:0]        o_tx_data_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done
);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_DONE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic        r_overflow;
    logic        r_tx_data_avail;
    logic [7:0]  r_tx_data_byte;

    fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DAT_W  (8)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (o_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A byte written this cycle is not visible here until the count updates.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !i_tx_active) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow      <= 1'b0;
            r_tx_data_avail <= 1'b0;
            r_tx_data_byte  <= 8'h00;
        end else begin
            r_overflow      <= i_wr_en && w_full;
            r_tx_data_avail <= w_pop;
            if (w_pop) begin
                r_tx_data_byte <= w_head;
            end
        end
    end

    assign o_full          = w_full;
    assign o_empty         = w_empty;
    assign o_overflow      = r_overflow;
    assign o_tx_data_avail = r_tx_data_avail;
    assign o_tx_data_byte  = r_tx_data_byte;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model for the multi-byte cases.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_wr_en = 1'b0;
    logic [7:0]        i_wr_data = 8'h00;
    logic              o_full;
    logic              o_empty;
    logic [ADDR_W:0]   o_count;
    logic              o_overflow;
    logic              o_tx_data_avail;
    logic [7:0]        o_tx_data_byte;
    logic              i_tx_active = 1'b0;
    logic              i_tx_done = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    bit        model_en  = 1'b0;
    int        frame_len = 20;
    bit        m_busy    = 1'b0;
    int        m_cnt     = 0;
    logic [7:0] m_byte   = 8'h00;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int        ovf_seen  = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_wr_en         (i_wr_en),
        .i_wr_data       (i_wr_data),
        .o_full          (o_full),
        .o_empty         (o_empty),
        .o_count         (o_count),
        .o_overflow      (o_overflow),
        .o_tx_data_avail (o_tx_data_avail),
        .o_tx_data_byte  (o_tx_data_byte),
        .i_tx_active     (i_tx_active),
        .i_tx_done       (i_tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_got(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            step();
            c++;
        end
        chk(tag, got_q.size(), n);
    endtask

    task automatic do_reset();
        model_en    = 1'b0;
        i_tx_active = 1'b0;
        i_tx_done   = 1'b0;
        i_wr_en     = 1'b0;
        rst         = 1'b1;
        step();
        rst         = 1'b0;
    endtask

    // Transmitter model: takes a byte on each start pulse, stays active frame_len cycles, then pulses done.
    always begin
        @(posedge clk);
        #2;
        if (o_overflow) ovf_seen++;
        if (!model_en) begin
            m_busy = 1'b0;
        end else begin
            if (i_tx_done) i_tx_done = 1'b0;
            if (o_tx_data_avail) begin
                chk("pulse_while_busy", {31'd0, m_busy | i_tx_active}, 32'd0);
                got_q.push_back(o_tx_data_byte);
                m_byte      = o_tx_data_byte;
                m_busy      = 1'b1;
                i_tx_active = 1'b1;
                m_cnt       = frame_len;
            end else if (m_busy) begin
                chk("byte_held", o_tx_data_byte, m_byte);
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy      = 1'b0;
                    i_tx_active = 1'b0;
                    i_tx_done   = 1'b1;
                end
            end
        end
    end

    initial begin
        step(2);
        rst = 1'b0;

        // Reset state and idle.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_avail", o_tx_data_avail, 1'b0);
        end
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_full", o_full, 1'b0);
        chk("rst_count", o_count, 0);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_byte", o_tx_data_byte, 8'h00);

        // Single byte, manual handshake.
        i_wr_en = 1'b1; i_wr_data = 8'hA5;
        step();
        i_wr_en = 1'b0;
        chk("one_empty", o_empty, 1'b0);
        chk("one_count", o_count, 1);
        chk("one_avail_early", o_tx_data_avail, 1'b0);
        step();
        chk("one_avail", o_tx_data_avail, 1'b1);
        chk("one_byte", o_tx_data_byte, 8'hA5);
        chk("one_count_pop", o_count, 0);
        step();
        chk("one_avail_1cyc", o_tx_data_avail, 1'b0);
        step(3);
        chk("one_byte_held", o_tx_data_byte, 8'hA5);
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("one_after_done_avail", o_tx_data_avail, 1'b0);
        step(2);
        chk("one_final_avail", o_tx_data_avail, 1'b0);
        chk("one_final_empty", o_empty, 1'b1);

        // Three bytes, 20-cycle frames.
        got_q.delete();
        frame_len = 20;
        model_en  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            i_wr_en = 1'b1; i_wr_data = 8'(i);
            step();
        end
        i_wr_en = 1'b0;
        wait_got("three_timeout", 3, 300);
        step(25);
        for (int i = 0; i < 3; i++) begin
            chk("three_order", (i < got_q.size()) ? got_q[i] : 8'hxx, 8'(i + 1));
        end
        chk("three_count", o_count, 0);

        // Stall the transmitter and overfill.
        do_reset();
        i_wr_en = 1'b1; i_wr_data = 8'h0F;
        step();
        i_wr_en = 1'b0;
        step();
        chk("stall_first_avail", o_tx_data_avail, 1'b1);
        chk("stall_first_byte", o_tx_data_byte, 8'h0F);
        i_tx_active = 1'b1;
        for (int i = 0; i < 17; i++) begin
            i_wr_en = 1'b1; i_wr_data = 8'(8'h10 + i);
            step();
            chk("stall_ovf", o_overflow, (i == 16) ? 1'b1 : 1'b0);
            chk("stall_no_pulse", o_tx_data_avail, 1'b0);
        end
        i_wr_en = 1'b0;
        step();
        chk("stall_ovf_clear", o_overflow, 1'b0);
        chk("stall_count", o_count, 16);
        chk("stall_full", o_full, 1'b1);

        // Full FIFO: pop and write in the same cycle.
        i_tx_active = 1'b0;
        i_tx_done   = 1'b1;
        step();
        i_tx_done = 1'b0;
        i_wr_en = 1'b1; i_wr_data = 8'h99;
        step();
        i_wr_en = 1'b0;
        chk("fullpop_avail", o_tx_data_avail, 1'b1);
        chk("fullpop_byte", o_tx_data_byte, 8'h10);
        chk("fullpop_count", o_count, DEPTH - 1);
        chk("fullpop_ovf", o_overflow, 1'b1);
        chk("fullpop_full", o_full, 1'b0);
        step();
        chk("fullpop_ovf_1cyc", o_overflow, 1'b0);
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        got_q.delete();
        frame_len = 2;
        model_en  = 1'b1;
        wait_got("drain_timeout", 15, 400);
        for (int i = 0; i < 15; i++) begin
            chk("drain_data", (i < got_q.size()) ? got_q[i] : 8'hxx, 8'(8'h11 + i));
        end

        // Reset mid-frame.
        do_reset();
        frame_len = 20;
        model_en  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_wr_en = 1'b1; i_wr_data = 8'(8'h30 + i);
            step();
        end
        i_wr_en = 1'b0;
        step(5);
        do_reset();
        chk("mid_rst_count", o_count, 0);
        chk("mid_rst_empty", o_empty, 1'b1);
        chk("mid_rst_avail", o_tx_data_avail, 1'b0);
        chk("mid_rst_byte", o_tx_data_byte, 8'h00);
        step(3);
        chk("mid_rst_idle", o_tx_data_avail, 1'b0);
        got_q.delete();
        frame_len = 4;
        model_en  = 1'b1;
        i_wr_en = 1'b1; i_wr_data = 8'h5A;
        step();
        i_wr_en = 1'b0;
        wait_got("fresh_timeout", 1, 50);
        chk("fresh_byte", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h5A);
        step(20);
        chk("fresh_only_one", got_q.size(), 1);

        // Wrap-around streaming in bursts.
        do_reset();
        got_q.delete();
        exp_q.delete();
        frame_len = 4;
        model_en  = 1'b1;
        ovf_seen  = 0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                i_wr_en   = 1'b1;
                i_wr_data = 8'((b * 10 + i) * 7 + 3);
                exp_q.push_back(i_wr_data);
                step();
            end
            i_wr_en = 1'b0;
            step(90);
        end
        wait_got("wrap_timeout", 40, 500);
        for (int i = 0; i < 40; i++) begin
            chk("wrap_data", (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        end
        chk("wrap_no_ovf", ovf_seen, 0);
        chk("wrap_empty", o_empty, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
